// File: rtl/demorgan_checker.sv
// Sweeps {A,B} through 00,01,10,11 into an external De Morgan stage and checks its four outputs.
// Define DEMORGAN_CHK_LOOP_EN for back-to-back accumulating sweeps and the sweep_cnt output.

module demorgan_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       nAandB,
    input  logic       nAornB,
    input  logic       nAorB,
    input  logic       nAandnB,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] fail_vec
`ifdef DEMORGAN_CHK_LOOP_EN
    ,
    output logic [7:0] sweep_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} stateType;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    stateType   state;
    stateType   nextState;
    logic [1:0] vec;
    logic [3:0] waitCnt;
    logic       hasFail;
    logic       mismatch;
    logic [2:0] errNext;

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves nextState unassigned (no latch).
        nextState = state;
        case (state)
            IDLE:  if (start) nextState = APPLY;
            APPLY: nextState = WAIT;
            WAIT:  if (waitCnt == SETTLE_LAST) nextState = CHECK;
            CHECK: nextState = (vec == 2'd3) ? DONE : APPLY;
`ifdef DEMORGAN_CHK_LOOP_EN
            DONE:  nextState = start ? APPLY : IDLE;
`else
            DONE:  nextState = IDLE;
`endif
            default: nextState = IDLE;
        endcase
    end

    // One vector counts once, however many of the four returned values are wrong.
    assign mismatch = (nAandB  != ~(A & B)) || (nAornB  != ~(A & B)) ||
                      (nAorB   != ~(A | B)) || (nAandnB != ~(A | B));
    assign errNext  = (err_cnt == 3'd7) ? 3'd7 : err_cnt + 3'd1;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= 2'd0;
            waitCnt   <= 4'd0;
            A         <= 1'b0;
            B         <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= 3'd0;
            fail_vec  <= 2'd0;
            hasFail   <= 1'b0;
`ifdef DEMORGAN_CHK_LOOP_EN
            sweep_cnt <= 8'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every flop here samples pre-edge values.
            state <= nextState;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec      <= 2'd0;
                        {A, B}   <= 2'd0;
                        pass     <= 1'b0;
                        err_cnt  <= 3'd0;
                        fail_vec <= 2'd0;
                        hasFail  <= 1'b0;
                    end
                end
                APPLY: waitCnt <= 4'd0;
                WAIT:  waitCnt <= waitCnt + 4'd1;
                CHECK: begin
                    if (mismatch) begin
                        err_cnt <= errNext;
                        if (!hasFail) begin
                            fail_vec <= {A, B};
                            hasFail  <= 1'b1;
                        end
                    end
                    if (vec == 2'd3) pass <= (err_cnt == 3'd0) && !mismatch;
                    // Index 3 wraps to 0: the outputs rest low in DONE and a looped sweep restarts at 00.
                    vec    <= vec + 2'd1;
                    {A, B} <= vec + 2'd1;
                end
                DONE: begin
`ifdef DEMORGAN_CHK_LOOP_EN
                    sweep_cnt <= sweep_cnt + 8'd1;
                    if (start) pass <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_demorgan_checker.sv
// Self-checking bench for demorgan_checker: fault-injecting De Morgan stage model, vector table,
// random sweeps against a reference model, reset and (with DEMORGAN_CHK_LOOP_EN) looped sweeps.

module tb_demorgan_checker;

    localparam logic [1:0] OK = 2'd0, F0 = 2'd1, F1 = 2'd2, INV = 2'd3;

    typedef struct packed {
        logic [2:0] err;
        logic       has;
        logic [1:0] fv;
    } refRes;

    typedef struct {
        string      name;
        logic [7:0] modes;
        logic       useLong;
        int         pulseK;
        logic [2:0] expErr;
        logic [1:0] expFv;
        logic       expPass;
    } vecRec;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic startReq = 1'b0;
    logic useLong = 1'b0;
    logic [7:0] faultModes = 8'd0;

    logic a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [1:0] fv1;
    logic a15, b15, busy15, done15, pass15;
    logic [2:0] err15;
    logic [1:0] fv15;
    logic [3:0] stage1, stage15;
`ifdef DEMORGAN_CHK_LOOP_EN
    logic [7:0] sc1, sc15;
`endif

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    // Stage outputs, bit 3..0 = nAandB, nAornB, nAorB, nAandnB; two mode bits per output.
    function automatic logic [3:0] stageOut(input logic a, input logic b, input logic [7:0] modes);
        logic [3:0] good;
        logic [3:0] res;
        logic nandV;
        logic norV;
        nandV = (a && b) ? 1'b0 : 1'b1;
        norV  = (a || b) ? 1'b0 : 1'b1;
        good  = {nandV, nandV, norV, norV};
        res   = good;
        for (int i = 0; i < 4; i++) begin
            case (modes[2*i +: 2])
                F0:      res[i] = 1'b0;
                F1:      res[i] = 1'b1;
                INV:     res[i] = ~good[i];
                default: res[i] = good[i];
            endcase
        end
        return res;
    endfunction

    function automatic logic [7:0] mk(input logic [1:0] mAnd, input logic [1:0] mOrn,
                                      input logic [1:0] mOr, input logic [1:0] mAndn);
        return {mAnd, mOrn, mOr, mAndn};
    endfunction

    // Reference: a sweep visits vectors 0..3; any wrong output flags the vector.
    function automatic refRes refSweep(input logic [7:0] modes, input refRes prior);
        refRes r;
        int e;
        r = prior;
        e = int'(prior.err);
        for (int v = 0; v < 4; v++) begin
            logic a;
            logic b;
            a = (v >= 2);
            b = (v % 2) == 1;
            if (stageOut(a, b, modes) != {!(a && b), !(a && b), !(a || b), !(a || b)}) begin
                e = (e + 1 > 7) ? 7 : e + 1;
                if (!r.has) begin
                    r.has = 1'b1;
                    r.fv  = 2'(v);
                end
            end
        end
        r.err = 3'(e);
        return r;
    endfunction

    assign stage1  = stageOut(a1, b1, faultModes);
    assign stage15 = stageOut(a15, b15, faultModes);

    demorgan_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(startReq & ~useLong),
        .A(a1), .B(b1),
        .nAandB(stage1[3]), .nAornB(stage1[2]), .nAorB(stage1[1]), .nAandnB(stage1[0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
`ifdef DEMORGAN_CHK_LOOP_EN
        , .sweep_cnt(sc1)
`endif
    );

    demorgan_checker #(.SETTLE(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .start(startReq & useLong),
        .A(a15), .B(b15),
        .nAandB(stage15[3]), .nAornB(stage15[2]), .nAorB(stage15[1]), .nAandnB(stage15[0]),
        .busy(busy15), .done(done15), .pass(pass15), .err_cnt(err15), .fail_vec(fv15)
`ifdef DEMORGAN_CHK_LOOP_EN
        , .sweep_cnt(sc15)
`endif
    );

    logic curA, curB, curBusy, curDone, curPass;
    logic [2:0] curErr;
    logic [1:0] curFv;
    assign curA    = useLong ? a15 : a1;
    assign curB    = useLong ? b15 : b1;
    assign curBusy = useLong ? busy15 : busy1;
    assign curDone = useLong ? done15 : done1;
    assign curPass = useLong ? pass15 : pass1;
    assign curErr  = useLong ? err15 : err1;
    assign curFv   = useLong ? fv15 : fv1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One start pulse, then watch every cycle: vector order, single done at 4*(SETTLE+2).
    task automatic runSweep(input string name, input logic [7:0] modes, input logic longSel,
                            input int pulseK, input logic [2:0] expErr,
                            input logic [1:0] expFv, input logic expPass);
        int period;
        int doneEdge;
        int doneAt;
        int doneCount;
        int abBad;
        logic [2:0] errAtDone;
        logic [1:0] fvAtDone;
        logic passAtDone;
        period    = (longSel ? 15 : 1) + 2;
        doneEdge  = 4 * period;
        doneAt    = -1;
        doneCount = 0;
        abBad     = 0;
        errAtDone = 3'd0;
        fvAtDone  = 2'd0;
        passAtDone = 1'b0;
        useLong    = longSel;
        faultModes = modes;
        @(negedge clk);
        startReq = 1'b1;
        @(negedge clk);
        for (int k = 0; k < doneEdge + 6; k++) begin
            if (k > 0) @(negedge clk);
            startReq = (k == pulseK);
            if (k < doneEdge && {curA, curB} !== 2'(k / period)) abBad++;
            if (curDone === 1'b1) begin
                doneCount++;
                if (doneAt < 0) doneAt = k;
            end
            if (k == doneEdge) begin
                errAtDone  = curErr;
                fvAtDone   = curFv;
                passAtDone = curPass;
            end
        end
        startReq = 1'b0;
        check({name, "_vector_order_errs"}, abBad, 0);
        check({name, "_done_edge"}, doneAt, doneEdge);
        check({name, "_done_count"}, doneCount, 1);
        check({name, "_err_cnt"}, errAtDone, expErr);
        check({name, "_fail_vec"}, fvAtDone, expFv);
        check({name, "_pass_at_done"}, passAtDone, expPass);
        check({name, "_pass_held"}, curPass, expPass);
        check({name, "_idle_busy_ab"}, {curBusy, curA, curB}, 3'b000);
    endtask

    vecRec table_[$];

    initial begin
        refRes r;
        refRes zero;
        int doneSeen;
        zero = '0;

        table_.push_back('{"clean",        mk(OK, OK, OK, OK),  1'b0, -1, 3'd0, 2'd0, 1'b1});
        table_.push_back('{"nAorB_f0",     mk(OK, OK, F0, OK),  1'b0, -1, 3'd1, 2'd0, 1'b0});
        table_.push_back('{"nAandB_f1",    mk(F1, OK, OK, OK),  1'b0, -1, 3'd1, 2'd3, 1'b0});
        table_.push_back('{"start_in_wait", mk(OK, OK, OK, OK), 1'b0,  4, 3'd0, 2'd0, 1'b1});
        table_.push_back('{"nAornB_inv",   mk(OK, INV, OK, OK), 1'b0, -1, 3'd4, 2'd0, 1'b0});
        table_.push_back('{"nAandnB_f1",   mk(OK, OK, OK, F1),  1'b0, -1, 3'd3, 2'd1, 1'b0});
        table_.push_back('{"nAornB_f0",    mk(OK, F0, OK, OK),  1'b0, -1, 3'd3, 2'd0, 1'b0});
        table_.push_back('{"and_f0_or_f1", mk(F0, OK, F1, OK),  1'b0, -1, 3'd4, 2'd0, 1'b0});
        table_.push_back('{"settle15",     mk(OK, OK, OK, OK),  1'b1, -1, 3'd0, 2'd0, 1'b1});

        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", {a1, b1, busy1, done1, pass1, err1, fv1}, 10'd0);
        check("reset_outputs_s15", {a15, b15, busy15, done15, pass15, err15, fv15}, 10'd0);
`ifdef DEMORGAN_CHK_LOOP_EN
        check("reset_sweep_cnt", sc1, 8'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (table_[i])
            runSweep(table_[i].name, table_[i].modes, table_[i].useLong, table_[i].pulseK,
                     table_[i].expErr, table_[i].expFv, table_[i].expPass);

        for (int n = 0; n < 10; n++) begin
            logic [7:0] m;
            logic longSel;
            int p;
            for (int i = 0; i < 4; i++)
                m[2*i +: 2] = ($urandom_range(0, 4) >= 2) ? OK : 2'($urandom_range(1, 3));
            longSel = (n == 9);
            p = longSel ? -1 : int'($urandom_range(1, 11));
            r = refSweep(m, zero);
            runSweep($sformatf("rand%0d", n), m, longSel, p, r.err, r.fv, (r.err == 3'd0));
        end

        // Reset in the middle of vector 10 with an error already recorded.
        useLong    = 1'b0;
        faultModes = mk(OK, OK, F0, OK);
        @(negedge clk);
        startReq = 1'b1;
        @(negedge clk);
        startReq = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_reset_vector", {a1, b1}, 2'b10);
        check("pre_reset_err", err1, 3'd1);
        rst_n = 1'b0;
        #1;
        check("midsweep_reset_outputs", {a1, b1, busy1, done1, pass1, err1, fv1}, 10'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done1 === 1'b1) doneSeen++;
        end
        check("no_done_after_reset", doneSeen, 0);
        runSweep("after_reset", mk(OK, OK, OK, OK), 1'b0, -1, 3'd0, 2'd0, 1'b1);

`ifdef DEMORGAN_CHK_LOOP_EN
        begin
            refRes r1;
            refRes r2;
            int doneCount;
            int doneFirst;
            int doneSecond;
            logic [2:0] e1;
            logic [2:0] e2;
            logic [1:0] f2;
            logic p2;
            logic [7:0] s2;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            useLong    = 1'b0;
            faultModes = mk(OK, OK, OK, INV);
            r1 = refSweep(faultModes, zero);
            r2 = refSweep(faultModes, r1);
            doneCount = 0;
            doneFirst = -1;
            doneSecond = -1;
            e1 = 3'd0; e2 = 3'd0; f2 = 2'd0; p2 = 1'b1; s2 = 8'd0;
            @(negedge clk);
            startReq = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 36; k++) begin
                if (k > 0) @(negedge clk);
                if (done1 === 1'b1) begin
                    doneCount++;
                    if (doneFirst < 0) doneFirst = k;
                    else if (doneSecond < 0) doneSecond = k;
                end
                if (k == 12) e1 = err1;
                if (k == 25) begin
                    e2 = err1;
                    f2 = fv1;
                    p2 = pass1;
                    startReq = 1'b0;
                end
                if (k == 26) s2 = sc1;
            end
            check("loop_done_count", doneCount, 2);
            check("loop_done_first", doneFirst, 12);
            check("loop_done_second", doneSecond, 25);
            check("loop_sweep1_err", e1, r1.err);
            check("loop_sweep2_err", e2, r2.err);
            check("loop_fail_vec", f2, r2.fv);
            check("loop_pass", p2, 1'b0);
            check("loop_sweep_cnt", s2, 8'd2);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
